mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the LC-3 datapath's MAR/MDR memory port. It accepts one read or write request at a time from the CPU control unit and waits a programmable number of cycles. It then performs the access against an on-chip word RAM or the memory-mapped I/O register, returns read data on `MDR_in` and pulses the ready flag `R` that the control FSM polls in its memory wait states.

## Interface
- `ADDR_W`, default 10: RAM address width in words. RAM occupies `0x0000` to `2^ADDR_W-1`. Legal range 1..15.
- `LATENCY`, default 2: number of wait cycles before the access is performed. Must be at least 1; 0 is illegal.

- `Clk`  in  1  sole clock; every register updates on its rising edge.
- `Reset`  in  1  synchronous, active-high.
- `MEM_REQ`  in  1  request strobe, sampled only in IDLE.
- `MEM_WE`  in  1  1 = write, 0 = read. Latched with the request.
- `MAR`  in  16  word address. Latched with the request.
- `MDR_out`  in  16  write data from the datapath MDR. Latched with the request.
- `SW`  in  16  switch inputs, readable at `0xFFFF`.
- `MDR_in`  out  16  read data to the datapath MDR mux.
- `R`  out  1  ready, a one-cycle pulse.
- `busy`  out  1  high whenever a transaction is in flight.
- `HEX_out`  out  16  display register, writable at `0xFFFF`.

## Operation
- The FSM has three states: IDLE, WAIT and DONE.
- **IDLE:** if `MEM_REQ`=1, latch `MAR`, `MEM_WE` and `MDR_out`, load `cnt`=LATENCY-1 and go to WAIT. Otherwise stay in IDLE.
- **WAIT:** if `cnt`≠0, decrement `cnt`. If `cnt`=0, perform the access on this edge and go to DONE.
- **DONE:** `R`=1 for this cycle, then go to IDLE unconditionally.
- `MEM_REQ` is ignored in WAIT and DONE. There is no queueing; a request held high in those states is not remembered.
- `busy` = (state ≠ IDLE).
- **Address decode** uses the latched address:
  - `0xFFFF`: a read returns `SW` as sampled on the access edge. A write loads `HEX_out`.
  - `MAR[15:ADDR_W]`=0: RAM word `MAR[ADDR_W-1:0]`. A write stores the data; a read returns the stored word.
  - Any other address: a read returns `0x0000`. A write is dropped, with no aliasing into RAM.
- **`MDR_in`:** loaded only on a read's access edge. It holds its value through later writes and idle periods until the next read completes.
- **RAM contents:** not reset. They are undefined until written. `Reset` never alters RAM.
- **Reset values:** state=IDLE, `cnt`=0, `R`=0, `busy`=0, `MDR_in`=`0x0000`, `HEX_out`=`0x0000`.
- **Reset mid-transaction:** the transaction is abandoned. A write whose access edge has not yet occurred is never performed. No `R` pulse is issued.
- **Reset together with an access edge:** reset wins. No RAM or `HEX_out` update takes place.

## Timing
- Let the request-sample edge be E0, i.e. the edge in IDLE with `MEM_REQ`=1.
- WAIT occupies the LATENCY cycles after E0.
- The access is performed on edge E(LATENCY).
- DONE is the cycle after E(LATENCY). `R`=1 and `MDR_in` (for reads) or `HEX_out` (for writes) is valid in that same cycle.
- The next edge returns the FSM to IDLE. The earliest next request-sample edge is E(LATENCY+2).
- Throughput is one transaction per LATENCY+2 cycles. Example: with LATENCY=2, `R` is high in cycle 3 when the request cycle is cycle 0.
- `R`, `busy`, `MDR_in` and `HEX_out` are registered outputs. None of them has a combinational path from any input.
- `MAR`, `MEM_WE` and `MDR_out` may change freely after E0. Only the latched copies are used.

## Test plan
- **Write then read RAM (LATENCY=2):** reset, then write `0x1234` to `0x0005`. `R` pulses in cycle 3 and `busy` is high in cycles 1-3. Then read `0x0005`: `MDR_in`=`0x1234` in the read's DONE cycle.
- **Memory-mapped I/O:** write `0xBEEF` to `0xFFFF`, so `HEX_out`=`0xBEEF` from DONE onward. Read `0xFFFF` with `SW`=`0x00A5`, so `MDR_in`=`0x00A5`. Change `SW` to `0x0000` after the access edge: `MDR_in` stays `0x00A5`.
- **Out-of-range access:** write `0x1111` to `0x0007`. Write `0xDEAD` to `0x0407`, which must not alias. Read `0x0407`: `MDR_in`=`0x0000`. Read `0x0007`: `MDR_in`=`0x1111`.
- **`MEM_REQ` held high:** hold `MEM_REQ` high continuously for 12 cycles with LATENCY=2. Exactly 3 `R` pulses appear, at cycles 3, 7 and 11. Toggling `MEM_REQ` during WAIT creates no extra transaction.
- **Reset mid-write:** with `0x0007`=`0x1111`, start a write of `0x2222` to `0x0007` and assert `Reset` in the first WAIT cycle. `R` never pulses. `busy`=0, `HEX_out`=`0x0000` and `MDR_in`=`0x0000` after the reset edge. A subsequent read of `0x0007` returns `0x1111`.
- **LATENCY=1 build:** `R` is high exactly 2 cycles after the request cycle. Back-to-back requests are sampled every 3 cycles.

Source files
------------

// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// LC-3 MAR/MDR memory responder: one request at a time, fixed wait latency,
// then an access to on-chip word RAM or the 0xFFFF switch/display register.
module mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_out,
  input  logic [15:0] SW,
  output logic [15:0] MDR_in,
  output logic        R,
  output logic        busy,
  output logic [15:0] HEX_out
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      addr_q, addr_d;
  logic             we_q, we_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic [15:0]      hex_q, hex_d;
  logic [15:0]      mdr_io_q, mdr_io_d;
  logic             src_ram_q, src_ram_d;

  logic [15:0]      ram [0:(1 << ADDR_W) - 1];
  logic [15:0]      ram_dout_q;

  logic             access;
  logic             is_io;
  logic             is_ram;
  logic [ADDR_W-1:0] ram_idx;

  assign is_io   = (addr_q == 16'hFFFF);
  assign is_ram  = (addr_q[15:ADDR_W] == '0);
  assign ram_idx = addr_q[ADDR_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    hex_d     = hex_q;
    mdr_io_d  = mdr_io_q;
    src_ram_d = src_ram_q;
    access    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (MEM_REQ) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = MAR;
          we_d    = MEM_WE;
          wdata_d = MDR_out;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
          access  = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Reads from RAM come out of the RAM's own output register; the mux
    // select is remembered so MDR_in holds until the next read completes.
    if (access) begin
      if (we_q) begin
        if (is_io) hex_d = wdata_q;
      end else begin
        src_ram_d = is_ram;
        mdr_io_d  = is_io ? SW : 16'h0000;
      end
    end

    r_d    = access;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= 16'h0000;
      we_q      <= 1'b0;
      wdata_q   <= 16'h0000;
      r_q       <= 1'b0;
      busy_q    <= 1'b0;
      hex_q     <= 16'h0000;
      mdr_io_q  <= 16'h0000;
      src_ram_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      r_q       <= r_d;
      busy_q    <= busy_d;
      hex_q     <= hex_d;
      mdr_io_q  <= mdr_io_d;
      src_ram_q <= src_ram_d;
    end
  end

  // RAM is never reset; a reset on the access edge suppresses the write.
  always_ff @(posedge Clk) begin
    if (access && !Reset) begin
      if (we_q) begin
        if (is_ram) ram[ram_idx] <= wdata_q;
      end else begin
        ram_dout_q <= ram[ram_idx];
      end
    end
  end

  assign MDR_in  = src_ram_q ? ram_dout_q : mdr_io_q;
  assign R       = r_q;
  assign busy    = busy_q;
  assign HEX_out = hex_q;

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
// Bench for mem_responder: LATENCY=2 instance driven from a vector table plus
// corner sequences, and a LATENCY=1 instance for the fast build.
module tb_mem_responder;

  localparam int LAT2 = 2;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] sw;
    logic [15:0] exp_md;
    logic [15:0] exp_hex;
  } vec_t;

  typedef struct {
    logic [15:0] md;
    logic [15:0] hex;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] sw;

  logic        req2, we2, r2, busy2;
  logic [15:0] mar2, wd2, md2, hex2;
  logic        req1, we1, r1, busy1;
  logic [15:0] mar1, wd1, md1, hex1;

  int   n_checks;
  int   n_fail;
  exp_t q2[$];
  exp_t q1[$];
  exp_t e2, e1;
  vec_t vecs[12];

  mem_responder #(.ADDR_W(10), .LATENCY(LAT2)) dut2 (
    .Clk(clk), .Reset(rst), .MEM_REQ(req2), .MEM_WE(we2), .MAR(mar2),
    .MDR_out(wd2), .SW(sw), .MDR_in(md2), .R(r2), .busy(busy2), .HEX_out(hex2)
  );

  mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .Clk(clk), .Reset(rst), .MEM_REQ(req1), .MEM_WE(we1), .MAR(mar1),
    .MDR_out(wd1), .SW(sw), .MDR_in(md1), .R(r1), .busy(busy1), .HEX_out(hex1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboards: every R pulse pops the oldest expected completion.
  always @(negedge clk) begin
    if (r2) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut2_unexpected_R: got R=1 expected no pending transaction");
      end else begin
        e2 = q2.pop_front();
        check("dut2_mdr_in", md2, e2.md);
        check("dut2_hex_out", hex2, e2.hex);
        $display("dut2 done: mdr_in=%h hex_out=%h", md2, hex2);
      end
    end
    if (r1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1_unexpected_R: got R=1 expected no pending transaction");
      end else begin
        e1 = q1.pop_front();
        check("dut1_mdr_in", md1, e1.md);
        check("dut1_hex_out", hex1, e1.hex);
        $display("dut1 done: mdr_in=%h hex_out=%h", md1, hex1);
      end
    end
  end

  // Called just after a rising edge with dut2 idle; returns at the earliest
  // cycle in which the next request can be sampled.
  task automatic txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [15:0] sw_val, input logic [15:0] exp_md,
                     input logic [15:0] exp_hex);
    exp_t e;
    e.md  = exp_md;
    e.hex = exp_hex;
    q2.push_back(e);
    req2 = 1'b1;
    we2  = we;
    mar2 = addr;
    wd2  = wdata;
    sw   = sw_val;
    for (int i = 0; i <= LAT2 + 1; i++) begin
      @(negedge clk);
      check("txn_busy", {15'b0, busy2}, {15'b0, i != 0});
      check("txn_R", {15'b0, r2}, {15'b0, i == LAT2 + 1});
      @(posedge clk);
      #1;
      if (i == 0) begin
        req2 = 1'b0;
        we2  = 1'($urandom);
        mar2 = 16'($urandom);
        wd2  = 16'($urandom);
      end
    end
  endtask

  // Start a write and reset dut2 during cycle rst_cycle (1 = first WAIT cycle).
  task automatic abort_write(input logic [15:0] addr, input logic [15:0] wdata,
                             input int rst_cycle);
    req2 = 1'b1;
    we2  = 1'b1;
    mar2 = addr;
    wd2  = wdata;
    @(posedge clk);
    #1;
    req2 = 1'b0;
    repeat (rst_cycle - 1) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_busy", {15'b0, busy2}, 16'h0);
      check("abort_R", {15'b0, r2}, 16'h0);
      check("abort_hex", hex2, 16'h0000);
      check("abort_mdr", md2, 16'h0000);
      @(posedge clk);
      #1;
    end
    $display("dut2 abort: write %h->%h reset in cycle %0d", wdata, addr, rst_cycle);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    sw  = 16'h0;
    req2 = 1'b0; we2 = 1'b0; mar2 = 16'h0; wd2 = 16'h0;
    req1 = 1'b0; we1 = 1'b0; mar1 = 16'h0; wd1 = 16'h0;

    //            we    addr      wdata     sw        exp_md    exp_hex
    vecs[0]  = '{1'b1, 16'h0005, 16'h1234, 16'h5555, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 16'h0005, 16'h0000, 16'h5555, 16'h1234, 16'h0000};
    vecs[2]  = '{1'b1, 16'hFFFF, 16'hBEEF, 16'h5555, 16'h1234, 16'hBEEF};
    vecs[3]  = '{1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h00A5, 16'hBEEF};
    vecs[4]  = '{1'b1, 16'h0007, 16'h1111, 16'h5555, 16'h00A5, 16'hBEEF};
    vecs[5]  = '{1'b1, 16'h0407, 16'hDEAD, 16'h5555, 16'h00A5, 16'hBEEF};
    vecs[6]  = '{1'b0, 16'h0407, 16'h0000, 16'h5555, 16'h0000, 16'hBEEF};
    vecs[7]  = '{1'b0, 16'h0007, 16'h0000, 16'h5555, 16'h1111, 16'hBEEF};
    vecs[8]  = '{1'b0, 16'h8000, 16'h0000, 16'h5555, 16'h0000, 16'hBEEF};
    vecs[9]  = '{1'b1, 16'h03FF, 16'h5A5A, 16'h5555, 16'h0000, 16'hBEEF};
    vecs[10] = '{1'b0, 16'hFFFE, 16'h0000, 16'h5555, 16'h0000, 16'hBEEF};
    vecs[11] = '{1'b0, 16'h03FF, 16'h0000, 16'h5555, 16'h5A5A, 16'hBEEF};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_R2", {15'b0, r2}, 16'h0);
    check("reset_busy2", {15'b0, busy2}, 16'h0);
    check("reset_mdr2", md2, 16'h0000);
    check("reset_hex2", hex2, 16'h0000);
    check("reset_R1", {15'b0, r1}, 16'h0);
    check("reset_busy1", {15'b0, busy1}, 16'h0);
    check("reset_mdr1", md1, 16'h0000);
    check("reset_hex1", hex1, 16'h0000);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      $display("vec %0d: we=%b addr=%h wdata=%h sw=%h", i, vecs[i].we, vecs[i].addr,
               vecs[i].wdata, vecs[i].sw);
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sw, vecs[i].exp_md,
          vecs[i].exp_hex);
    end

    // Switch value is captured only on the access edge.
    txn(1'b0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h00A5, 16'hBEEF);
    sw = 16'h0000;
    repeat (3) begin
      @(negedge clk);
      check("sw_hold_mdr", md2, 16'h00A5);
    end
    @(posedge clk);
    #1;

    // MEM_REQ held high for 12 cycles: completions at cycles 3, 7, 11.
    for (int k = 0; k < 3; k++) q2.push_back('{16'h00A5, 16'hBEEF});
    req2 = 1'b1; we2 = 1'b1; mar2 = 16'h0009; wd2 = 16'h7777;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("held_R", {15'b0, r2}, {15'b0, (i == 3) || (i == 7) || (i == 11)});
      check("held_busy", {15'b0, busy2}, {15'b0, (i % 4) != 0});
      @(posedge clk);
      #1;
    end
    req2 = 1'b0;

    // MEM_REQ toggled during WAIT/DONE: one transaction only.
    q2.push_back('{16'h1234, 16'hBEEF});
    we2 = 1'b0; mar2 = 16'h0005;
    for (int i = 0; i < 8; i++) begin
      req2 = (i == 0) || (i == 1) || (i == 3);
      @(negedge clk);
      check("toggle_R", {15'b0, r2}, {15'b0, i == 3});
      @(posedge clk);
      #1;
    end
    req2 = 1'b0;

    abort_write(16'h0007, 16'h2222, 1);
    txn(1'b0, 16'h0007, 16'h0000, 16'h5555, 16'h1111, 16'h0000);
    abort_write(16'h0007, 16'h3333, 2);
    txn(1'b0, 16'h0007, 16'h0000, 16'h5555, 16'h1111, 16'h0000);

    // LATENCY=1: two held writes (R at 2, 5) then a read (R at 8).
    q1.push_back('{16'h0000, 16'h0000});
    q1.push_back('{16'h0000, 16'h0000});
    q1.push_back('{16'h4321, 16'h0000});
    mar1 = 16'h0003; wd1 = 16'h4321;
    for (int i = 0; i < 10; i++) begin
      req1 = (i <= 6);
      we1  = (i < 6);
      @(negedge clk);
      check("lat1_R", {15'b0, r1}, {15'b0, (i == 2) || (i == 5) || (i == 8)});
      check("lat1_busy", {15'b0, busy1}, {15'b0, (i % 3) != 0});
      @(posedge clk);
      #1;
    end
    req1 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("q2_drained", 16'(q2.size()), 16'h0);
    check("q1_drained", 16'(q1.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
